jk_register_sequencer: RTL and testbench

//   Command-driven controller for a WIDTH-bit register built from JK flip-flop cells.

---
 rtl/jk_cmd_if.sv | 28 ++
 rtl/jk_register_sequencer.sv | 144 ++++++++++++++
 tb/tb_jk_register_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_if.sv
// Command channel into the JK register sequencer: valid/ready handshake carrying
// the opcode, the load value and the count step total.
interface jk_cmd_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/jk_register_sequencer.sv
// Command-driven sequencer for a WIDTH-bit register of JK cells: turns
// CLEAR/LOAD/COUNT_UP/COUNT_DOWN commands into per-bit J/K excitation.

module jk_cell (
    input  logic Clk,
    input  logic Rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge Clk) begin
        if (!Rst)
            q <= 1'b0;
        else
            q <= (j & ~q) | (~k & q);
    end
endmodule

module jk_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    jk_cmd_if.slave          cmd,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // op[1] marks the COUNT_* commands, which run for a step count instead of one cycle
    wire accept    = cmd.cmd_valid & ready_q;
    wire zero_cnt  = cmd.cmd_op[1] & (cmd.cmd_steps == '0);
    wire last_step = ~op_q[1] | (cnt == CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= cmd.cmd_op;
                        data_q  <= cmd.cmd_data;
                        cnt     <= cmd.cmd_steps;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (zero_cnt) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Counting toggles bit i when every lower bit is 1 (up) or 0 (down): a ripple of ANDs
    logic run;
    always_comb begin
        J   = '0;
        K   = '0;
        run = 1'b1;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_CLEAR: K = '1;
                OP_LOAD: begin
                    J = data_q;
                    K = ~data_q;
                end
                default: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        J[i] = run;
                        K[i] = run;
                        run  = run & ((op_q == OP_UP) ? Q[i] : ~Q[i]);
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_cell u_cell (
            .Clk (Clk),
            .Rst (Rst),
            .j   (J[b]),
            .k   (K[b]),
            .q   (Q[b])
        );
    end

    wire unused_down = (OP_DOWN == op_q);
endmodule

// File: tb/tb_jk_register_sequencer.sv
// Directed bench for jk_register_sequencer; observes {J,K,Q,ready,busy,done} each negedge.
module tb_jk_register_sequencer;
    logic       Clk;
    logic       Rst;
    logic [3:0] J, K, Q;
    logic       busy, done;
    int         checks;
    int         failures;

    jk_cmd_if #(.WIDTH(4), .CNT_W(8)) cmd ();

    jk_register_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .cmd  (cmd),
        .J    (J),
        .K    (K),
        .Q    (Q),
        .busy (busy),
        .done (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [14:0] obs;
    assign obs = {J, K, Q, cmd.cmd_ready, busy, done};

    // Presents a command from a negedge, holds it over one rising edge, then scrambles it
    task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [7:0] s);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_data  = d;
        cmd.cmd_steps = s;
        @(posedge Clk);
        #1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = ~op;
        cmd.cmd_data  = ~d;
        cmd.cmd_steps = 8'hff;
    endtask

    task automatic preload(input logic [3:0] d);
        send(2'b01, d, 8'd0);
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [14:0] exp = {4'b0000, 4'b0000, 4'b0000, 3'b100};
        Rst = 1'b0;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_data  = 4'b0000;
        cmd.cmd_steps = 8'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_load();
        logic [14:0] exp [3] = '{
            {4'b1010, 4'b0101, 4'b0000, 3'b010},
            {4'b0000, 4'b0000, 4'b1010, 3'b011},
            {4'b0000, 4'b0000, 4'b1010, 3'b100}};
        send(2'b01, 4'b1010, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL load cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    // Issued in the first IDLE cycle after the preload's DONE, so it also covers back-to-back
    task automatic test_count_up_wrap();
        logic [14:0] exp [5] = '{
            {4'b0001, 4'b0001, 4'b1110, 3'b010},
            {4'b1111, 4'b1111, 4'b1111, 3'b010},
            {4'b0001, 4'b0001, 4'b0000, 3'b010},
            {4'b0000, 4'b0000, 4'b0001, 3'b011},
            {4'b0000, 4'b0000, 4'b0001, 3'b100}};
        preload(4'b1110);
        send(2'b10, 4'b0000, 8'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL count_up cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_count_down();
        logic [14:0] exp [4] = '{
            {4'b0001, 4'b0001, 4'b0001, 3'b010},
            {4'b1111, 4'b1111, 4'b0000, 3'b010},
            {4'b0000, 4'b0000, 4'b1111, 3'b011},
            {4'b0000, 4'b0000, 4'b1111, 3'b100}};
        send(2'b11, 4'b0000, 8'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL count_down cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_zero_steps();
        logic [14:0] exp [3] = '{
            {4'b0000, 4'b0000, 4'b0101, 3'b011},
            {4'b0000, 4'b0000, 4'b0101, 3'b100},
            {4'b0000, 4'b0000, 4'b0101, 3'b100}};
        preload(4'b0101);
        send(2'b10, 4'b0000, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL zero_steps cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
            // A LOAD offered only while busy must never be latched
            cmd.cmd_valid = (i == 0);
            cmd.cmd_op    = 2'b01;
            cmd.cmd_data  = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [14:0] exp_run [5] = '{
            {4'b0001, 4'b0001, 4'b0000, 3'b010},
            {4'b0011, 4'b0011, 4'b0001, 3'b010},
            {4'b0001, 4'b0001, 4'b0010, 3'b010},
            {4'b0111, 4'b0111, 4'b0011, 3'b010},
            {4'b0001, 4'b0001, 4'b0100, 3'b010}};
        logic [14:0] exp_idle = {4'b0000, 4'b0000, 4'b0000, 3'b100};
        logic [14:0] exp_clr [3] = '{
            {4'b0000, 4'b1111, 4'b1111, 3'b010},
            {4'b0000, 4'b0000, 4'b0000, 3'b011},
            {4'b0000, 4'b0000, 4'b0000, 3'b100}};
        preload(4'b0000);
        send(2'b10, 4'b0000, 8'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_run[i]) begin
                failures++;
                $display("FAIL mid_run cyc%0d got=%b exp=%b", i, obs, exp_run[i]);
            end
        end
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp_idle) begin
                failures++;
                $display("FAIL mid_reset cyc%0d got=%b exp=%b", i, obs, exp_idle);
            end
            @(negedge Clk);
        end
        preload(4'b1111);
        send(2'b00, 4'b0000, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_clr[i]) begin
                failures++;
                $display("FAIL clear cyc%0d got=%b exp=%b", i, obs, exp_clr[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load();
        test_count_up_wrap();
        test_count_down();
        test_zero_steps();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
